// File: rtl/axil_uart_pkg.sv
// Shared constants and FSM state types for the AXI4-Lite UART controller.
package axil_uart_pkg;

    // Register word indices, decoded from address bits [3:2]
    localparam logic [1:0] ADDR_RX   = 2'd0;
    localparam logic [1:0] ADDR_TX   = 2'd1;
    localparam logic [1:0] ADDR_STAT = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    // STAT register bit positions
    localparam int unsigned STAT_RX_VALID = 0;
    localparam int unsigned STAT_RX_EN    = 1;
    localparam int unsigned STAT_TX_FULL  = 3;
    localparam int unsigned STAT_INTR_EN  = 4;

    // CTRL register bit positions
    localparam int unsigned CTRL_RX_EN   = 0;
    localparam int unsigned CTRL_INTR_EN = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;

endpackage

// File: rtl/axil_uart_ctrl.sv
// AXI4-Lite register front end for a UART FIFO pair: register map, FIFO
// push/pop strobes, receiver enable and edge-triggered interrupt.
// All outputs are registered so they are all low while reset is asserted.
// The cycle with AWREADY/ARREADY high is the accept cycle; strobes fire there.
module axil_uart_ctrl
    import axil_uart_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [7:0]                      RX_data,
    input  logic                            Empty,
    output logic                            rd_uart_en,
    output logic [7:0]                      TX_data,
    output logic                            wr_uart_en,
    input  logic                            Full,
    output logic                            Enable_rx,
    output logic                            Interrupt
);

    wr_state_e r_wstate, w_wstate_d;
    rd_state_e r_rstate, w_rstate_d;

    logic                          r_awready, w_awready_d;
    logic                          r_bvalid, w_bvalid_d;
    logic [1:0]                    r_bresp, w_bresp_d;
    logic                          r_wr_en, w_wr_en_d;
    logic [7:0]                    r_tx_data, w_tx_data_d;
    logic                          r_rx_en, w_rx_en_d;
    logic                          r_intr_en, w_intr_en_d;
    logic                          r_arready, w_arready_d;
    logic                          r_rvalid, w_rvalid_d;
    logic [1:0]                    r_rresp, w_rresp_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata, w_rdata_d;
    logic                          r_rd_en, w_rd_en_d;
    logic                          r_empty_dly, r_full_dly;
    logic                          r_intr, w_intr_d;
    logic                          w_aw_go, w_ar_go;
    logic                          w_unused;

    // Only word-aligned byte lane 0 carries meaningful write data
    assign w_unused = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WDATA[31:5],
                        S_AXI_WDATA[3:1], S_AXI_WSTRB[3:1]};

    // A request is decided one cycle before its READY pulse; the pulse cycle blocks re-decision
    assign w_aw_go = (r_wstate == W_IDLE) && !r_awready && S_AXI_AWVALID && S_AXI_WVALID;
    assign w_ar_go = (r_rstate == R_IDLE) && !r_arready && S_AXI_ARVALID;

    // State registers for both channel FSMs
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_d;
            r_rstate <= w_rstate_d;
        end
    end

    // Next-state logic: enter response state after the accept cycle, leave on handshake
    always_comb begin
        w_wstate_d = r_wstate;
        w_rstate_d = r_rstate;
        unique case (r_wstate)
            W_IDLE:  if (r_awready) w_wstate_d = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_wstate_d = W_IDLE;
            default: w_wstate_d = W_IDLE;
        endcase
        unique case (r_rstate)
            R_IDLE:  if (r_arready) w_rstate_d = R_DATA;
            R_DATA:  if (S_AXI_RREADY) w_rstate_d = R_IDLE;
            default: w_rstate_d = R_IDLE;
        endcase
    end

    // Write channel outputs, TX push and CTRL update
    always_comb begin
        w_awready_d = 1'b0;
        w_wr_en_d   = 1'b0;
        w_tx_data_d = r_tx_data;
        w_bresp_d   = r_bresp;
        w_bvalid_d  = r_bvalid;
        w_rx_en_d   = r_rx_en;
        w_intr_en_d = r_intr_en;
        if (w_aw_go) begin
            w_awready_d = 1'b1;
            w_bresp_d   = RESP_SLVERR;
            case (S_AXI_AWADDR[3:2])
                ADDR_TX: begin
                    if (!S_AXI_WSTRB[0]) begin
                        w_bresp_d = RESP_OKAY;
                    end else if (!Full) begin
                        w_bresp_d   = RESP_OKAY;
                        w_wr_en_d   = 1'b1;
                        w_tx_data_d = S_AXI_WDATA[7:0];
                    end
                end
                ADDR_CTRL: begin
                    w_bresp_d = RESP_OKAY;
                    if (S_AXI_WSTRB[0]) begin
                        w_rx_en_d   = S_AXI_WDATA[CTRL_RX_EN];
                        w_intr_en_d = S_AXI_WDATA[CTRL_INTR_EN];
                    end
                end
                default: ;
            endcase
        end
        if (r_awready) w_bvalid_d = 1'b1;
        if ((r_wstate == W_RESP) && S_AXI_BREADY) w_bvalid_d = 1'b0;
    end

    // Read channel outputs and RX pop; read data is frozen once captured
    always_comb begin
        w_arready_d = 1'b0;
        w_rd_en_d   = 1'b0;
        w_rdata_d   = r_rdata;
        w_rresp_d   = r_rresp;
        w_rvalid_d  = r_rvalid;
        if (w_ar_go) begin
            w_arready_d = 1'b1;
            w_rresp_d   = RESP_OKAY;
            w_rdata_d   = '0;
            case (S_AXI_ARADDR[3:2])
                ADDR_RX: begin
                    if (!Empty) begin
                        w_rdata_d[7:0] = RX_data;
                        w_rd_en_d      = 1'b1;
                    end else begin
                        w_rresp_d = RESP_SLVERR;
                    end
                end
                ADDR_STAT: begin
                    w_rdata_d[STAT_RX_VALID] = !Empty;
                    w_rdata_d[STAT_RX_EN]    = r_rx_en;
                    w_rdata_d[STAT_TX_FULL]  = Full;
                    w_rdata_d[STAT_INTR_EN]  = r_intr_en;
                end
                ADDR_CTRL: begin
                    w_rdata_d[CTRL_RX_EN]   = r_rx_en;
                    w_rdata_d[CTRL_INTR_EN] = r_intr_en;
                end
                default: ;
            endcase
        end
        if (r_arready) w_rvalid_d = 1'b1;
        if ((r_rstate == R_DATA) && S_AXI_RREADY) w_rvalid_d = 1'b0;
    end

    // Interrupt on RX-not-empty rising or TX-full falling; edges while disabled are dropped
    always_comb begin
        w_intr_d = r_intr_en && ((r_empty_dly && !Empty) || (r_full_dly && !Full));
    end

    // Registered outputs and edge-detect history
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_awready   <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= RESP_OKAY;
            r_wr_en     <= 1'b0;
            r_tx_data   <= '0;
            r_rx_en     <= 1'b0;
            r_intr_en   <= 1'b0;
            r_arready   <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rresp     <= RESP_OKAY;
            r_rdata     <= '0;
            r_rd_en     <= 1'b0;
            r_empty_dly <= 1'b1;
            r_full_dly  <= 1'b0;
            r_intr      <= 1'b0;
        end else begin
            r_awready   <= w_awready_d;
            r_bvalid    <= w_bvalid_d;
            r_bresp     <= w_bresp_d;
            r_wr_en     <= w_wr_en_d;
            r_tx_data   <= w_tx_data_d;
            r_rx_en     <= w_rx_en_d;
            r_intr_en   <= w_intr_en_d;
            r_arready   <= w_arready_d;
            r_rvalid    <= w_rvalid_d;
            r_rresp     <= w_rresp_d;
            r_rdata     <= w_rdata_d;
            r_rd_en     <= w_rd_en_d;
            r_empty_dly <= Empty;
            r_full_dly  <= Full;
            r_intr      <= w_intr_d;
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_awready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RDATA   = r_rdata;
    assign wr_uart_en    = r_wr_en;
    assign TX_data       = r_tx_data;
    assign rd_uart_en    = r_rd_en;
    assign Enable_rx     = r_rx_en;
    assign Interrupt     = r_intr;

endmodule

// File: tb/tb_axil_uart_ctrl.sv
// Randomised self-checking bench for axil_uart_ctrl with a behavioural model.
module tb_axil_uart_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        empty = 1'b1;
    logic        rd_en;
    logic [7:0]  tx_data;
    logic        wr_en;
    logic        full = 1'b0;
    logic        enable_rx;
    logic        intr;

    int checks = 0;
    int errors = 0;
    int n_wr = 0;
    int n_rd = 0;
    int n_irq = 0;

    // Model state: CTRL contents and last-cycle FIFO flags
    logic m_en = 1'b0, m_ie = 1'b0, pe = 1'b1, pf = 1'b0, exp_irq = 1'b0;

    axil_uart_ctrl dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .RX_data      (rx_data),
        .Empty        (empty),
        .rd_uart_en   (rd_en),
        .TX_data      (tx_data),
        .wr_uart_en   (wr_en),
        .Full         (full),
        .Enable_rx    (enable_rx),
        .Interrupt    (intr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle model: interrupt pulses, receiver enable, strobe counting
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            m_en = 1'b0; m_ie = 1'b0; pe = 1'b1; pf = 1'b0; exp_irq = 1'b0;
        end else begin
            if (wr_en) n_wr++;
            if (rd_en) n_rd++;
            if (intr) n_irq++;
            chk("interrupt", intr, exp_irq);
            if (awready && awaddr[3:2] == 2'd3 && wstrb[0]) begin
                m_en = wdata[0];
                m_ie = wdata[4];
            end
            chk("enable_rx", enable_rx, m_en);
            exp_irq = m_ie && ((pe && !empty) || (pf && !full));
            pe = empty;
            pf = full;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            empty   = 1'($urandom_range(0, 1));
            full    = 1'($urandom_range(0, 1));
            rx_data = 8'($urandom);
        end
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int bdly, output logic [1:0] resp);
        int wc0;
        logic push;
        logic [1:0] er;
        wc0 = n_wr; push = 1'b0; er = 2'b10;
        case (addr[3:2])
            2'd1: if (!strb[0]) er = 2'b00; else if (!full) begin push = 1'b1; er = 2'b00; end
            2'd3: er = 2'b00;
            default: ;
        endcase
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20 && !awready; i++) @(negedge clk);
        chk("awready", awready, 1);
        chk("wready", wready, 1);
        chk("wr_uart_en", wr_en, push);
        if (push) chk("tx_data", tx_data, data[7:0]);
        @(posedge clk);
        #1 awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 20 && !bvalid; i++) @(negedge clk);
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, er);
        chk("awready_pulse", awready, 0);
        resp = bresp;
        repeat (bdly) begin
            @(negedge clk);
            chk("bvalid_hold", bvalid, 1);
            chk("bresp_hold", bresp, er);
        end
        @(posedge clk);
        #1 bready = 1'b1;
        @(posedge clk);
        #1 bready = 1'b0;
        @(negedge clk);
        chk("bvalid_clear", bvalid, 0);
        chk("wr_count", n_wr - wc0, push);
        @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input logic [3:0] addr, input int rdly, output logic [31:0] dout);
        int rc0;
        logic pop;
        logic [1:0] er;
        logic [31:0] ed;
        rc0 = n_rd; pop = 1'b0; er = 2'b00; ed = '0;
        case (addr[3:2])
            2'd0: if (!empty) begin ed = {24'd0, rx_data}; pop = 1'b1; end else er = 2'b10;
            2'd2: ed = 32'(!empty) + 32'(m_en) * 2 + 32'(full) * 8 + 32'(m_ie) * 16;
            2'd3: ed = 32'(m_en) + 32'(m_ie) * 16;
            default: ed = '0;
        endcase
        araddr = addr; arvalid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20 && !arready; i++) @(negedge clk);
        chk("arready", arready, 1);
        chk("rd_uart_en", rd_en, pop);
        @(posedge clk);
        #1 arvalid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 20 && !rvalid; i++) @(negedge clk);
        chk("rvalid", rvalid, 1);
        chk("rdata", rdata, ed);
        chk("rresp", rresp, er);
        dout = rdata;
        repeat (rdly) begin
            @(negedge clk);
            chk("rvalid_hold", rvalid, 1);
            chk("rdata_hold", rdata, ed);
            chk("rresp_hold", rresp, er);
        end
        @(posedge clk);
        #1 rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
        @(negedge clk);
        chk("rvalid_clear", rvalid, 0);
        chk("rd_count", n_rd - rc0, pop);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk(nm, {31'd0, |{awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata,
                          tx_data, wr_en, rd_en, enable_rx, intr}}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r, r2;
        logic [31:0] d, d2;
        int i0;

        #1;
        chk_outputs_zero("reset_outputs");
        cycles(3);
        rst_n = 1'b1;
        idle(3);

        // Directed: TX push, TX full, RX pop, RX empty
        full = 1'b0;
        axi_write(4'h4, 32'h41, 4'h1, 1, r);
        chk("tp_tx_okay", r, 2'b00);
        full = 1'b1;
        axi_write(4'h4, 32'h42, 4'h1, 0, r);
        chk("tp_tx_full_slverr", r, 2'b10);
        empty = 1'b0; rx_data = 8'h5A;
        axi_read(4'h0, 0, d);
        chk("tp_rx_data", d, 32'h5A);
        empty = 1'b1;
        axi_read(4'h0, 0, d);
        chk("tp_rx_empty", d, 32'h0);

        // CTRL and STAT, then interrupt edges
        axi_write(4'hC, 32'h11, 4'h1, 0, r);
        empty = 1'b0; full = 1'b1;
        axi_read(4'h8, 0, d);
        chk("tp_stat", d, 32'h1B);
        chk("tp_enable_rx", enable_rx, 1);
        empty = 1'b1;
        cycles(3);
        i0 = n_irq;
        empty = 1'b0;
        cycles(3);
        chk("tp_irq_empty_edge", n_irq - i0, 1);
        i0 = n_irq;
        full = 1'b0;
        cycles(3);
        chk("tp_irq_full_edge", n_irq - i0, 1);

        // Stalled R channel: data held and a single pop
        rx_data = 8'hC3;
        axi_read(4'h0, 5, d);
        chk("tp_stall_rdata", d, 32'hC3);

        // Reset while BVALID is pending
        full = 1'b0;
        awaddr = 4'h4; wdata = 32'h33; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20 && !awready; i++) @(negedge clk);
        @(posedge clk);
        #1 awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        chk("rst_mid_bvalid", bvalid, 1);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("rst_mid_outputs");
        cycles(2);
        chk_outputs_zero("rst_hold_outputs");
        rst_n = 1'b1;
        cycles(2);
        axi_write(4'h4, 32'h77, 4'h1, 0, r);
        chk("rst_after_write", r, 2'b00);

        // Randomised traffic, including concurrent TX push and RX pop
        for (int t = 0; t < 150; t++) begin
            int op;
            logic [3:0] a, a2;
            idle($urandom_range(1, 4));
            op = $urandom_range(0, 2);
            a  = 4'($urandom_range(0, 15));
            if (op == 0) begin
                axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), r);
            end else if (op == 1) begin
                axi_read(a, $urandom_range(0, 3), d);
            end else begin
                a2 = 4'($urandom_range(0, 2) * 4 + $urandom_range(0, 3));
                fork
                    axi_write(a2, $urandom, 4'($urandom), $urandom_range(0, 3), r2);
                    axi_read(a, $urandom_range(0, 3), d2);
                join
            end
        end

        // Edges while intr_en is clear are lost
        axi_write(4'hC, 32'h01, 4'h1, 0, r);
        empty = 1'b1; full = 1'b1;
        cycles(3);
        i0 = n_irq;
        empty = 1'b0; full = 1'b0;
        cycles(4);
        chk("tp_irq_disabled", n_irq - i0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
